// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single SPI memory read engine between the
// instruction-fetch and data-fetch requesters. It sequences the engine's
// level start/done handshake, arbitrates ties, and aborts hung reads.
module mem_arbiter #(
  parameter bit          DATA_PRIORITY  = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  input  logic [2:0]  i_bytes,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [23:0] d_addr,
  input  logic [2:0]  d_bytes,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_start,
  output logic [23:0] mem_addr,
  output logic [2:0]  mem_bytes,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTES_W = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Transfer ownership, tie-break pointer, served flags, watchdog.
  logic               grant_data_q;
  logic               rr_data_q;
  logic               served_i_q;
  logic               served_d_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               grant_data_d;
  logic               rr_data_d;
  logic               served_i_d;
  logic               served_d_d;
  logic [CNT_W-1:0]   cnt_d;

  logic               mem_start_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [BYTES_W-1:0] mem_bytes_d;
  logic               i_done_d;
  logic               d_done_d;
  logic               i_err_d;
  logic               d_err_d;
  logic [DATA_W-1:0]  i_rdata_d;
  logic [DATA_W-1:0]  d_rdata_d;
  logic               busy_d;

  // Shared arbitration and completion terms.
  logic               elig_i;
  logic               elig_d;
  logic               any_elig;
  logic               pick_data;
  logic               can_grant;
  logic               launch;
  logic               complete;
  logic               abort;
  logic               finish;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  // Eligibility, winner selection and watchdog expiry.
  always_comb begin
    elig_i      = i_req & ~served_i_q;
    elig_d      = d_req & ~served_d_q;
    any_elig    = elig_i | elig_d;
    pick_data   = elig_d & (~elig_i | DATA_PRIORITY | rr_data_q);
    cnt_inc     = cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (cnt_inc == TIMEOUT_CYCLES);
    can_grant   = (state_q == ST_IDLE) || ((state_q == ST_RELEASE) && !mem_done);
    launch      = can_grant & any_elig;
    complete    = (state_q == ST_ISSUE) & mem_done;
    abort       = (state_q == ST_ISSUE) & ~mem_done & timeout_hit;
    finish      = complete | abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (finish) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!mem_done) state_d = any_elig ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    mem_start_d  = launch | ((state_q == ST_ISSUE) & ~finish);
    mem_addr_d   = mem_addr;
    mem_bytes_d  = mem_bytes;
    grant_data_d = grant_data_q;
    rr_data_d    = rr_data_q;
    cnt_d        = cnt_q;
    i_done_d     = finish & ~grant_data_q;
    d_done_d     = finish & grant_data_q;
    i_err_d      = abort & ~grant_data_q;
    d_err_d      = abort & grant_data_q;
    i_rdata_d    = i_rdata;
    d_rdata_d    = d_rdata;
    served_i_d   = served_i_q;
    served_d_d   = served_d_q;
    busy_d       = (state_d != ST_IDLE);

    if (launch) begin
      mem_addr_d   = pick_data ? d_addr : i_addr;
      mem_bytes_d  = pick_data ? d_bytes : i_bytes;
      grant_data_d = pick_data;
      rr_data_d    = ~pick_data;
      cnt_d        = '0;
    end else if (state_q == ST_ISSUE) begin
      cnt_d = cnt_inc;
    end

    if (finish) begin
      if (grant_data_q) begin
        d_rdata_d  = complete ? mem_rdata : '0;
        served_d_d = 1'b1;
      end else begin
        i_rdata_d  = complete ? mem_rdata : '0;
        served_i_d = 1'b1;
      end
    end

    // A dropped request always re-arms its requester.
    if (!i_req) served_i_d = 1'b0;
    if (!d_req) served_d_d = 1'b0;
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_start    <= 1'b0;
      mem_addr     <= '0;
      mem_bytes    <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_err        <= 1'b0;
      d_err        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      busy         <= 1'b0;
      grant_data_q <= 1'b0;
      rr_data_q    <= 1'b0;
      served_i_q   <= 1'b0;
      served_d_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mem_start    <= mem_start_d;
      mem_addr     <= mem_addr_d;
      mem_bytes    <= mem_bytes_d;
      i_done       <= i_done_d;
      d_done       <= d_done_d;
      i_err        <= i_err_d;
      d_err        <= d_err_d;
      i_rdata      <= i_rdata_d;
      d_rdata      <= d_rdata_d;
      busy         <= busy_d;
      grant_data_q <= grant_data_d;
      rr_data_q    <= rr_data_d;
      served_i_q   <= served_i_d;
      served_d_q   <= served_d_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (round-robin with an 8-cycle watchdog, and
// data-priority with the watchdog disabled), each driven against a small
// behavioural read-engine model, with grant/completion scoreboards.
`timescale 1ns/1ps
module tb_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [23:0] addr;
    logic [2:0]  bytes;
  } grant_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        i_req     [2];
  logic [23:0] i_addr    [2];
  logic [2:0]  i_bytes   [2];
  logic        i_done    [2];
  logic [31:0] i_rdata   [2];
  logic        i_err     [2];
  logic        d_req     [2];
  logic [23:0] d_addr    [2];
  logic [2:0]  d_bytes   [2];
  logic        d_done    [2];
  logic [31:0] d_rdata   [2];
  logic        d_err     [2];
  logic        mem_start [2];
  logic [23:0] mem_addr  [2];
  logic [2:0]  mem_bytes [2];
  logic        mem_done  [2] = '{1'b0, 1'b0};
  logic [31:0] mem_rdata [2] = '{32'h0, 32'h0};
  logic        busy      [2];

  // Engine model controls (bench) and state (engine process).
  logic        eng_en   [2];
  int          eng_lat  [2];
  int          eng_cnt  [2] = '{0, 0};
  logic        eng_low  [2] = '{1'b0, 1'b0};

  grant_t      gq [2][$];
  done_t       dq [2][$];
  logic        start_prev [2] = '{1'b0, 1'b0};
  logic [31:0] last_i [2] = '{32'h0, 32'h0};
  logic [31:0] last_d [2] = '{32'h0, 32'h0};

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(16'd8)) u_rr (
    .clk(clk), .rst(rst),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_bytes(i_bytes[0]),
    .i_done(i_done[0]), .i_rdata(i_rdata[0]), .i_err(i_err[0]),
    .d_req(d_req[0]), .d_addr(d_addr[0]), .d_bytes(d_bytes[0]),
    .d_done(d_done[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]),
    .mem_start(mem_start[0]), .mem_addr(mem_addr[0]), .mem_bytes(mem_bytes[0]),
    .mem_done(mem_done[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(16'd0)) u_dp (
    .clk(clk), .rst(rst),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_bytes(i_bytes[1]),
    .i_done(i_done[1]), .i_rdata(i_rdata[1]), .i_err(i_err[1]),
    .d_req(d_req[1]), .d_addr(d_addr[1]), .d_bytes(d_bytes[1]),
    .d_done(d_done[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]),
    .mem_start(mem_start[1]), .mem_addr(mem_addr[1]), .mem_bytes(mem_bytes[1]),
    .mem_done(mem_done[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  function automatic logic [31:0] exp_data(input logic [23:0] a);
    logic [31:0] r;
    if (a == 24'h000010) r = 32'hDEADBEEF;
    else                 r = {8'hC3, a};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read engine: done after eng_lat start-high cycles, held until start has
  // been seen low for one extra sample (exercises the RELEASE wait).
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mem_done[k] = 1'b0;
        eng_low[k]  = 1'b0;
        eng_cnt[k]  = 0;
      end else if (!mem_start[k]) begin
        if (mem_done[k] && !eng_low[k]) begin
          eng_low[k] = 1'b1;
        end else begin
          mem_done[k] = 1'b0;
          eng_low[k]  = 1'b0;
        end
        eng_cnt[k] = 0;
      end else if (!mem_done[k]) begin
        eng_cnt[k] = eng_cnt[k] + 1;
        if (eng_en[k] && eng_cnt[k] >= eng_lat[k]) begin
          mem_done[k]  = 1'b1;
          mem_rdata[k] = exp_data(mem_addr[k]);
        end
      end
    end
  end

  // Scoreboard monitor: grants on mem_start rise, completions on done pulses.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        last_i[k]     = 32'h0;
        last_d[k]     = 32'h0;
        start_prev[k] = 1'b0;
      end else begin
        if (mem_start[k] && !start_prev[k]) begin
          chk($sformatf("grant_expected_%0d", k), 32'(gq[k].size() != 0), 32'd1);
          if (gq[k].size() != 0) begin
            grant_t g;
            g = gq[k].pop_front();
            chk($sformatf("grant_addr_%0d", k), 32'(mem_addr[k]), 32'(g.addr));
            chk($sformatf("grant_bytes_%0d", k), 32'(mem_bytes[k]), 32'(g.bytes));
          end
        end
        if (i_done[k] || d_done[k]) begin
          chk($sformatf("dual_done_%0d", k), 32'(i_done[k] & d_done[k]), 32'd0);
          chk($sformatf("done_expected_%0d", k), 32'(dq[k].size() != 0), 32'd1);
          if (dq[k].size() != 0) begin
            done_t e;
            e = dq[k].pop_front();
            chk($sformatf("done_who_%0d", k), 32'(d_done[k]), 32'(e.is_d));
            if (e.is_d) begin
              chk($sformatf("d_rdata_%0d", k), d_rdata[k], e.rdata);
              chk($sformatf("d_err_%0d", k), 32'(d_err[k]), 32'(e.err));
              chk($sformatf("i_rdata_kept_%0d", k), i_rdata[k], last_i[k]);
              last_d[k] = e.rdata;
            end else begin
              chk($sformatf("i_rdata_%0d", k), i_rdata[k], e.rdata);
              chk($sformatf("i_err_%0d", k), 32'(i_err[k]), 32'(e.err));
              chk($sformatf("d_rdata_kept_%0d", k), d_rdata[k], last_d[k]);
              last_i[k] = e.rdata;
            end
          end
        end
      end
      start_prev[k] = mem_start[k];
    end
  end

  task automatic expect_xfer(input int k, input logic is_d, input logic [23:0] a,
                             input logic [2:0] b, input logic err);
    grant_t g;
    done_t  e;
    g.is_d = is_d; g.addr = a; g.bytes = b;
    e.is_d = is_d; e.rdata = err ? 32'h0 : exp_data(a); e.err = err;
    gq[k].push_back(g);
    dq[k].push_back(e);
  endtask

  task automatic raise_i(input int k, input logic [23:0] a, input logic [2:0] b);
    i_addr[k] = a; i_bytes[k] = b; i_req[k] = 1'b1;
  endtask

  task automatic raise_d(input int k, input logic [23:0] a, input logic [2:0] b);
    d_addr[k] = a; d_bytes[k] = b; d_req[k] = 1'b1;
  endtask

  task automatic wait_done(input int k, input logic is_d);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? d_done[k] : i_done[k];
    end
    chk($sformatf("done_arrived_%0d_%0d", k, is_d), 32'(seen), 32'd1);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while ((gq[k].size() != 0 || dq[k].size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drained_%0d", k), 32'(gq[k].size() + dq[k].size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ctrl_%0d", k),
          32'({mem_start[k], i_done[k], d_done[k], i_err[k], d_err[k], busy[k]}), 32'd0);
      chk($sformatf("reset_i_rdata_%0d", k), i_rdata[k], 32'h0);
      chk($sformatf("reset_d_rdata_%0d", k), d_rdata[k], 32'h0);
      chk($sformatf("reset_mem_%0d", k), 32'({mem_bytes[k], mem_addr[k]}), 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic flag;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = 24'h0; i_bytes[k] = 3'd0;
      d_req[k] = 1'b0; d_addr[k] = 24'h0; d_bytes[k] = 3'd0;
      eng_en[k] = 1'b1; eng_lat[k] = 3;
    end
    do_reset();

    // Single instruction fetch, 20-cycle engine, watchdog disabled.
    eng_lat[1] = 20;
    expect_xfer(1, 1'b0, 24'h000010, 3'd4, 1'b0);
    @(negedge clk);
    raise_i(1, 24'h000010, 3'd4);
    @(negedge clk);
    chk("start_one_cycle_after_req", 32'(mem_start[1]), 32'd1);
    wait_done(1, 1'b0);
    // Held request after done must not be re-granted.
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_start[1]) flag = 1'b1;
    end
    chk("held_req_no_regrant", 32'(flag), 32'd0);
    chk("held_req_idle_busy", 32'(busy[1]), 32'd0);
    i_req[1] = 1'b0;
    @(negedge clk);
    eng_lat[1] = 4;
    expect_xfer(1, 1'b0, 24'h000020, 3'd2, 1'b0);
    raise_i(1, 24'h000020, 3'd2);
    wait_done(1, 1'b0);
    i_req[1] = 1'b0;
    drain(1);

    // Data priority: ties always go to data, including when round-robin would differ.
    do_reset();
    expect_xfer(1, 1'b1, 24'h000200, 3'd4, 1'b0);
    expect_xfer(1, 1'b0, 24'h000100, 3'd4, 1'b0);
    raise_i(1, 24'h000100, 3'd4);
    raise_d(1, 24'h000200, 3'd4);
    wait_done(1, 1'b1);
    d_req[1] = 1'b0;
    wait_done(1, 1'b0);
    i_req[1] = 1'b0;
    drain(1);
    expect_xfer(1, 1'b1, 24'h000210, 3'd1, 1'b0);
    raise_d(1, 24'h000210, 3'd1);
    wait_done(1, 1'b1);
    d_req[1] = 1'b0;
    drain(1);
    expect_xfer(1, 1'b1, 24'h000220, 3'd3, 1'b0);
    expect_xfer(1, 1'b0, 24'h000120, 3'd3, 1'b0);
    raise_i(1, 24'h000120, 3'd3);
    raise_d(1, 24'h000220, 3'd3);
    wait_done(1, 1'b1);
    d_req[1] = 1'b0;
    wait_done(1, 1'b0);
    i_req[1] = 1'b0;
    drain(1);

    // Round-robin with both held: I, D, I, D.
    do_reset();
    expect_xfer(0, 1'b0, 24'h000300, 3'd4, 1'b0);
    expect_xfer(0, 1'b1, 24'h000400, 3'd4, 1'b0);
    expect_xfer(0, 1'b0, 24'h000304, 3'd2, 1'b0);
    expect_xfer(0, 1'b1, 24'h000404, 3'd2, 1'b0);
    raise_i(0, 24'h000300, 3'd4);
    raise_d(0, 24'h000400, 3'd4);
    wait_done(0, 1'b0);
    i_req[0] = 1'b0;
    @(negedge clk);
    raise_i(0, 24'h000304, 3'd2);
    wait_done(0, 1'b1);
    d_req[0] = 1'b0;
    @(negedge clk);
    raise_d(0, 24'h000404, 3'd2);
    wait_done(0, 1'b0);
    i_req[0] = 1'b0;
    wait_done(0, 1'b1);
    d_req[0] = 1'b0;
    drain(0);

    // Watchdog: hung data read aborts after 8 ISSUE cycles; pending fetch follows.
    do_reset();
    eng_en[0] = 1'b0;
    expect_xfer(0, 1'b1, 24'h000500, 3'd4, 1'b1);
    expect_xfer(0, 1'b0, 24'h000600, 3'd4, 1'b0);
    raise_d(0, 24'h000500, 3'd4);
    n = 0;
    flag = 1'b0;
    for (int c = 0; c < 40 && !flag; c++) begin
      @(negedge clk);
      if (c == 1) raise_i(0, 24'h000600, 3'd4);
      if (d_done[0]) flag = 1'b1;
      else if (mem_start[0]) n++;
    end
    chk("timeout_seen", 32'(flag), 32'd1);
    chk("timeout_issue_cycles", 32'(n), 32'd8);
    chk("timeout_start_low", 32'(mem_start[0]), 32'd0);
    eng_en[0] = 1'b1;
    d_req[0] = 1'b0;
    wait_done(0, 1'b0);
    i_req[0] = 1'b0;
    drain(0);

    // Reset 5 cycles into ISSUE, then a normal grant.
    eng_en[0] = 1'b0;
    expect_xfer(0, 1'b0, 24'h000700, 3'd4, 1'b0);
    void'(dq[0].pop_back());
    raise_i(0, 24'h000700, 3'd4);
    flag = 1'b0;
    for (int c = 0; c < 10 && !flag; c++) begin
      @(negedge clk);
      flag = mem_start[0];
    end
    chk("rst_case_started", 32'(flag), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_issue_start", 32'(mem_start[0]), 32'd0);
    chk("rst_mid_issue_busy", 32'(busy[0]), 32'd0);
    chk("rst_mid_issue_done", 32'({i_done[0], d_done[0]}), 32'd0);
    eng_en[0] = 1'b1;
    expect_xfer(0, 1'b0, 24'h000700, 3'd4, 1'b0);
    rst = 1'b0;
    wait_done(0, 1'b0);
    i_req[0] = 1'b0;
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
